div_mod_iter: RTL and testbench

DIV_MOD_ITER -- requirements
Module: div_mod_iter

---
 rtl/div_mod_pkg.sv | 14 +
 rtl/div_mod_step.sv | 23 ++
 rtl/div_mod_iter.sv | 145 ++++++++++++++
 tb/tb_div_mod_iter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_mod_pkg.sv
// Shared definitions for the iterative signed divider: controller states and mode encodings.
package div_mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_QUOT = 1'b0;
  localparam logic MODE_REM  = 1'b1;

endpackage

// File: rtl/div_mod_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_mod_step
  import div_mod_pkg::*;
#(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dvs_mag,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;

  // rem_in < dvs_mag, so the shifted value needs one extra bit but the result never does
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, dvs_mag};
  assign q_bit   = (shifted >= {1'b0, dvs_mag});
  assign rem_out = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/div_mod_iter.sv
// Iterative signed divider: one restoring step per cycle on operand magnitudes, then sign fix-up
// and quotient saturation; returns either the quotient or the remainder.
module div_mod_iter
  import div_mod_pkg::*;
#(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16,
  parameter int OUT_W      = DIVISOR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  input  logic                         mode,
  input  logic                         valid_input,
  output logic                         in_ready,
  output logic                         valid_output,
  output logic signed [OUT_W-1:0]      final_output,
  output logic                         err_div0,
  output logic                         err_ovf
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  localparam logic [DIVIDEND_W:0] POS_LIM =
    {{(DIVIDEND_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic [DIVIDEND_W:0] NEG_LIM = POS_LIM + 1'b1;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  q_bit;
  logic                  neg_dvd;
  logic                  neg_dvs;
  logic                  mode_r;
  logic                  accept;
  logic                  last_step;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(W-1) without wrapping
  function automatic logic [DIVIDEND_W-1:0] mag_dvd(input logic signed [DIVIDEND_W-1:0] x);
    return x[DIVIDEND_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [DIVISOR_W-1:0] mag_dvs(input logic signed [DIVISOR_W-1:0] x);
    return x[DIVISOR_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Returns {overflow, saturated signed quotient}
  function automatic logic [OUT_W:0] sat_quot(input logic [DIVIDEND_W-1:0] mag,
                                              input logic                  neg);
    logic [DIVIDEND_W:0]      mag_x;
    logic signed [OUT_W-1:0]  val;
    mag_x = {1'b0, mag};
    if (!neg && (mag_x > POS_LIM)) return {1'b1, OUT_MAX};
    if (neg && (mag_x > NEG_LIM))  return {1'b1, OUT_MIN};
    val = OUT_W'(mag);
    if (neg) val = -val;
    return {1'b0, val};
  endfunction

  function automatic logic signed [OUT_W-1:0] fix_rem(input logic [DIVISOR_W-1:0] mag,
                                                      input logic                 neg);
    logic signed [DIVISOR_W:0] r;
    r = $signed({1'b0, mag});
    if (neg) r = -r;
    return OUT_W'(r);
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = valid_input && in_ready;
  assign last_step = (cnt == CNT_W'(DIVIDEND_W - 1));

  div_mod_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (dq[DIVIDEND_W-1]),
    .dvs_mag (dvs_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_step) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      valid_output <= 1'b0;
      final_output <= '0;
      err_div0     <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      state        <= state_nxt;
      valid_output <= (state_nxt == DONE);
      if (state == IDLE) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      // Result registers change only on the edge that enters DONE
      if (accept && (divisor == '0)) begin
        final_output <= '0;
        err_div0     <= 1'b1;
        err_ovf      <= 1'b0;
      end else if (state == FIX) begin
        err_div0 <= 1'b0;
        if (mode_r == MODE_REM) begin
          final_output <= fix_rem(rem, neg_dvd);
          err_ovf      <= 1'b0;
        end else begin
          {err_ovf, final_output} <= sat_quot(dq, neg_dvd ^ neg_dvs);
        end
      end
    end
  end

  // dq holds the unconsumed dividend bits and collects quotient bits from the bottom
  always_ff @(posedge clk) begin
    if (accept) begin
      dq      <= mag_dvd(dividend);
      dvs_mag <= mag_dvs(divisor);
      rem     <= '0;
      neg_dvd <= dividend[DIVIDEND_W-1];
      neg_dvs <= divisor[DIVISOR_W-1];
      mode_r  <= mode;
    end else if (state == RUN) begin
      dq  <= {dq[DIVIDEND_W-2:0], q_bit};
      rem <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_div_mod_iter.sv
// Directed bench for div_mod_iter with default widths (32 / 16 / 17).
module tb_div_mod_iter;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] dividend;
  logic signed [15:0] divisor;
  logic               mode;
  logic               valid_input;
  logic               in_ready;
  logic               valid_output;
  logic signed [16:0] final_output;
  logic               err_div0;
  logic               err_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_mod_iter #(
    .DIVIDEND_W (32),
    .DIVISOR_W  (16),
    .OUT_W      (17)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dividend     (dividend),
    .divisor      (divisor),
    .mode         (mode),
    .valid_input  (valid_input),
    .in_ready     (in_ready),
    .valid_output (valid_output),
    .final_output (final_output),
    .err_div0     (err_div0),
    .err_ovf      (err_ovf)
  );

  // Issues one request and returns the number of cycles until valid_output (100 = timed out)
  task automatic do_req(input logic signed [31:0] a, input logic signed [15:0] b,
                        input logic m, output int lat);
    @(negedge clk);
    dividend    = a;
    divisor     = b;
    mode        = m;
    valid_input = 1'b1;
    @(posedge clk);
    #1 valid_input = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (valid_output) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_input = 1'b0;
    dividend = '0;
    divisor = '0;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_output !== 1'b0 || final_output !== 17'sd0 || err_div0 !== 1'b0 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: vo=%b fo=%0d d0=%b ovf=%b, want all 0",
               valid_output, final_output, err_div0, err_ovf);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_quot_basic();
    int lat;
    do_req(32'sd100, 16'sd7, 1'b0, lat);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL quot_latency: got %0d want 34", lat);
    end
    checks++;
    if (final_output !== 17'sd14 || err_ovf !== 1'b0 || err_div0 !== 1'b0) begin
      failures++;
      $display("FAIL quot_100_7: fo=%0d ovf=%b d0=%b want 14 0 0", final_output, err_ovf, err_div0);
    end
    @(negedge clk);
    checks++;
    if (valid_output !== 1'b0 || in_ready !== 1'b1 || final_output !== 17'sd14) begin
      failures++;
      $display("FAIL quot_after_done: vo=%b rdy=%b fo=%0d want 0 1 14", valid_output, in_ready, final_output);
    end
  endtask

  task automatic test_negative();
    int lat;
    do_req(-32'sd100, 16'sd7, 1'b1, lat);
    checks++;
    if (lat !== 34 || final_output !== -17'sd2 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL rem_m100_7: lat=%0d fo=%0d ovf=%b want 34 -2 0", lat, final_output, err_ovf);
    end
    do_req(-32'sd100, 16'sd7, 1'b0, lat);
    checks++;
    if (lat !== 34 || final_output !== -17'sd14 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL quot_m100_7: lat=%0d fo=%0d ovf=%b want 34 -14 0", lat, final_output, err_ovf);
    end
    do_req(32'sd100, -16'sd7, 1'b1, lat);
    checks++;
    if (final_output !== 17'sd2) begin
      failures++;
      $display("FAIL rem_100_m7: fo=%0d want 2", final_output);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_req(32'sd1048576, 16'sd1, 1'b0, lat);
    checks++;
    if (final_output !== 17'sd65535 || err_ovf !== 1'b1 || err_div0 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_2p20: fo=%0d ovf=%b d0=%b want 65535 1 0", final_output, err_ovf, err_div0);
    end
    do_req(32'sh8000_0000, -16'sd1, 1'b0, lat);
    checks++;
    if (final_output !== 17'sd65535 || err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_min_m1: fo=%0d ovf=%b want 65535 1", final_output, err_ovf);
    end
    do_req(-32'sd1048576, 16'sd1, 1'b0, lat);
    checks++;
    if (final_output !== -17'sd65536 || err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_neg: fo=%0d ovf=%b want -65536 1", final_output, err_ovf);
    end
    do_req(-32'sd65536, 16'sd1, 1'b0, lat);
    checks++;
    if (final_output !== -17'sd65536 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL neg_bound: fo=%0d ovf=%b want -65536 0", final_output, err_ovf);
    end
  endtask

  task automatic test_div0();
    int lat;
    do_req(32'sd55, 16'sd0, 1'b0, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL div0_latency: got %0d want 1", lat);
    end
    checks++;
    if (final_output !== 17'sd0 || err_div0 !== 1'b1 || err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL div0_result: fo=%0d d0=%b ovf=%b want 0 1 0", final_output, err_div0, err_ovf);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || valid_output !== 1'b0) begin
      failures++;
      $display("FAIL div0_ready: rdy=%b vo=%b want 1 0", in_ready, valid_output);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n = 0;
    int first_i = -1;
    int second_i = -1;
    int pulses = 0;
    int lat;
    int extra = 0;
    logic signed [16:0] first_val = '0;
    @(negedge clk);
    dividend    = 32'sd100;
    divisor     = 16'sd7;
    mode        = 1'b0;
    valid_input = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) dividend = 32'sd200;
      if (valid_output) begin
        pulses++;
        first_val = final_output;
      end
      if (in_ready) begin
        acc_n++;
        if (acc_n == 1) first_i = i;
        else second_i = i;
      end
      @(negedge clk);
    end
    valid_input = 1'b0;
    checks++;
    if (acc_n !== 2 || (second_i - first_i) !== 35) begin
      failures++;
      $display("FAIL b2b_accepts: n=%0d spacing=%0d want 2 35", acc_n, second_i - first_i);
    end
    checks++;
    if (pulses !== 1 || first_val !== 17'sd14) begin
      failures++;
      $display("FAIL b2b_first: pulses=%0d fo=%0d want 1 14", pulses, first_val);
    end
    lat = 0;
    while (lat < 100 && !valid_output) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 29 || final_output !== 17'sd28 || err_div0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: wait=%0d fo=%0d d0=%b want 29 28 0", lat, final_output, err_div0);
    end
    repeat (40) begin
      @(negedge clk);
      if (valid_output) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL b2b_no_queue: extra pulses=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    int lat;
    @(negedge clk);
    dividend    = 32'sd100;
    divisor     = 16'sd7;
    mode        = 1'b0;
    valid_input = 1'b1;
    @(posedge clk);
    #1 valid_input = 1'b0;
    repeat (10) @(negedge clk);
    reset       = 1'b0;
    dividend    = -32'sd100;
    mode        = 1'b1;
    valid_input = 1'b1;
    @(negedge clk);
    checks++;
    if (final_output !== 17'sd0 || err_div0 !== 1'b0 || err_ovf !== 1'b0 || valid_output !== 1'b0) begin
      failures++;
      $display("FAIL midrun_cleared: fo=%0d d0=%b ovf=%b vo=%b want 0 0 0 0",
               final_output, err_div0, err_ovf, valid_output);
    end
    reset       = 1'b1;
    valid_input = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_ready: in_ready=%b want 1", in_ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (valid_output) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midrun_no_pulse: pulses=%0d want 0", pulses);
    end
    do_req(-32'sd100, 16'sd7, 1'b1, lat);
    checks++;
    if (lat !== 34 || final_output !== -17'sd2) begin
      failures++;
      $display("FAIL midrun_recover: lat=%0d fo=%0d want 34 -2", lat, final_output);
    end
  endtask

  initial begin
    test_reset();
    test_quot_basic();
    test_negative();
    test_overflow();
    test_div0();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
